// File: rtl/src_oneshot_drum.sv
// One-shot drum voice: swept triangle tone mixed with LFSR noise, shaped by an
// attack/decay envelope and emitted once per pblrc sample tick, two mclk cycles later.
module src_oneshot_drum #(
  parameter int VOLUME_BITS = 8,
  parameter int PHASE_BITS  = 16,
  parameter int FREQ_START  = 2048,
  parameter int FREQ_END    = 512,
  parameter int SWEEP_STEP  = 8,
  parameter int SWEEP_DIV   = 4,
  parameter int ATTACK_STEP = 32,
  parameter int DECAY_DIV   = 16,
  parameter int MIX_BITS    = 4
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   pblrc,
  input  logic                   trig,
  input  logic [MIX_BITS-1:0]    noise_mix,
  output logic signed [15:0]     p_sample_buffer,
  output logic                   sample_valid,
  output logic                   busy,
  output logic [VOLUME_BITS-1:0] volume_out,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ATTACK = 2'd1,
    S_DECAY  = 2'd2
  } state_e;

  localparam int SW_W = $clog2(SWEEP_DIV + 1);
  localparam int DC_W = $clog2(DECAY_DIV + 1);
  localparam int MW   = 16 + MIX_BITS + 2;
  localparam int PW   = 16 + VOLUME_BITS + 1;
  localparam logic [VOLUME_BITS-1:0] VMAX = {VOLUME_BITS{1'b1}};

  state_e                 state_q, state_d;
  logic [PHASE_BITS-1:0]  phase_q, phase_d;
  logic [PHASE_BITS-1:0]  freq_q, freq_d;
  logic [VOLUME_BITS-1:0] vol_q, vol_d;
  logic [SW_W-1:0]        sw_cnt_q, sw_cnt_d;
  logic [DC_W-1:0]        dc_cnt_q, dc_cnt_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   pblrc_q, trig_q, tick_q, valid_q;
  logic signed [15:0]     sample_q, sample_d;

  logic                   tick, trig_edge;
  logic [VOLUME_BITS:0]   vol_sum;

  assign tick      = pblrc & ~pblrc_q;
  assign trig_edge = trig & ~trig_q;
  assign vol_sum   = {1'b0, vol_q} + (VOLUME_BITS+1)'(ATTACK_STEP);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    freq_d   = freq_q;
    vol_d    = vol_q;
    sw_cnt_d = sw_cnt_q;
    dc_cnt_d = dc_cnt_q;
    lfsr_d   = lfsr_q;
    if (tick) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // A trigger edge preempts any envelope/sweep/phase step on the same cycle.
    if (trig_edge) begin
      if (state_q == S_IDLE) begin
        phase_d = '0;
        vol_d   = '0;
      end
      freq_d   = PHASE_BITS'(FREQ_START);
      sw_cnt_d = '0;
      dc_cnt_d = '0;
      state_d  = S_ATTACK;
    end else if (tick && state_q != S_IDLE) begin
      phase_d = phase_q + freq_q;
      if (sw_cnt_q == SW_W'(SWEEP_DIV - 1)) begin
        sw_cnt_d = '0;
        if ({1'b0, freq_q} >= (PHASE_BITS+1)'(FREQ_END + SWEEP_STEP))
          freq_d = freq_q - PHASE_BITS'(SWEEP_STEP);
        else
          freq_d = PHASE_BITS'(FREQ_END);
      end else begin
        sw_cnt_d = sw_cnt_q + 1'b1;
      end
      if (state_q == S_ATTACK) begin
        if (vol_sum >= {1'b0, VMAX}) begin
          vol_d   = VMAX;
          state_d = S_DECAY;
        end else begin
          vol_d = vol_sum[VOLUME_BITS-1:0];
        end
      end else begin
        if (dc_cnt_q == DC_W'(DECAY_DIV - 1)) begin
          dc_cnt_d = '0;
          if (vol_q <= VOLUME_BITS'(1)) begin
            vol_d   = '0;
            state_d = S_IDLE;
          end else begin
            vol_d = vol_q - 1'b1;
          end
        end else begin
          dc_cnt_d = dc_cnt_q + 1'b1;
        end
      end
    end
  end

  // Sample datapath runs one cycle after the tick, from the freshly stepped state.
  logic [14:0]              tri_u;
  logic signed [15:0]       tone, noise, mix;
  logic signed [MIX_BITS+1:0] w_noise, w_tone;
  logic signed [MW-1:0]     mix_full, mix_sh;
  logic signed [PW-1:0]     prod, prod_sh;
  logic unused_bits;

  always_comb begin
    tri_u    = phase_q[PHASE_BITS-1] ? ~phase_q[PHASE_BITS-2 -: 15] : phase_q[PHASE_BITS-2 -: 15];
    tone     = $signed({tri_u, 1'b0} ^ 16'h8000);
    noise    = $signed(lfsr_q);
    w_noise  = $signed({2'b00, noise_mix});
    w_tone   = $signed((MIX_BITS+2)'(2**MIX_BITS)) - w_noise;
    mix_full = MW'(tone) * MW'(w_tone) + MW'(noise) * MW'(w_noise);
    mix_sh   = mix_full >>> MIX_BITS;
    mix      = mix_sh[15:0];
    prod     = PW'(mix) * PW'($signed({1'b0, vol_q}));
    prod_sh  = prod >>> VOLUME_BITS;
    sample_d = sample_q;
    if (tick_q) sample_d = (state_q == S_IDLE) ? 16'sd0 : prod_sh[15:0];
  end

  assign unused_bits = ^{phase_q, mix_sh, prod_sh, vol_sum};

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      freq_q   <= PHASE_BITS'(FREQ_START);
      vol_q    <= '0;
      sw_cnt_q <= '0;
      dc_cnt_q <= '0;
      lfsr_q   <= 16'hACE1;
      pblrc_q  <= 1'b0;
      trig_q   <= 1'b0;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      freq_q   <= freq_d;
      vol_q    <= vol_d;
      sw_cnt_q <= sw_cnt_d;
      dc_cnt_q <= dc_cnt_d;
      lfsr_q   <= lfsr_d;
      pblrc_q  <= pblrc;
      trig_q   <= trig;
      tick_q   <= tick;
      valid_q  <= tick_q;
      sample_q <= sample_d;
    end
  end

  assign p_sample_buffer = sample_q;
  assign sample_valid    = valid_q;
  assign busy            = (state_q != S_IDLE);
  assign volume_out      = vol_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_src_oneshot_drum.sv
// Bench for src_oneshot_drum: directed note scenarios, a reference model pushes
// expected samples and their arrival cycle; a monitor pops on sample_valid.
module tb_src_oneshot_drum;

  logic        mclk = 1'b0;
  logic        rst = 1'b0;
  logic        pblrc = 1'b0;
  logic        trig = 1'b0;
  logic [3:0]  noise_mix = 4'd0;
  logic signed [15:0] p_sample_buffer;
  logic        sample_valid;
  logic        busy;
  logic [7:0]  volume_out;
  logic [1:0]  dbg_state;

  src_oneshot_drum dut (
    .mclk            (mclk),
    .rst             (rst),
    .pblrc           (pblrc),
    .trig            (trig),
    .noise_mix       (noise_mix),
    .p_sample_buffer (p_sample_buffer),
    .sample_valid    (sample_valid),
    .busy            (busy),
    .volume_out      (volume_out),
    .dbg_state       (dbg_state)
  );

  // clock / reset / cycle counter
  always #5 mclk = ~mclk;
  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  int          exp_t_q[$];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // reference model of the voice
  int          m_state, m_freq, m_vol, m_sw, m_dc;
  logic [15:0] m_phase, m_lfsr;
  bit          m_trig_prev;

  task automatic model_reset();
    m_state = 0; m_freq = 2048; m_vol = 0; m_sw = 0; m_dc = 0;
    m_phase = 16'd0; m_lfsr = 16'hACE1; m_trig_prev = 1'b0;
  endtask

  function automatic int exp_sample();
    logic [14:0] pu;
    int u, tone, noise, m, mix;
    if (m_state == 0) return 0;
    pu    = m_phase[15] ? ~m_phase[14:0] : m_phase[14:0];
    u     = int'(pu);
    tone  = 2 * u - 32768;
    noise = int'($signed(m_lfsr));
    m     = int'(noise_mix);
    mix   = (tone * (16 - m) + noise * m) >>> 4;
    return (mix * m_vol) >>> 8;
  endfunction

  // drive pins for the current cycle and advance the model to match
  task automatic apply(input bit tk, input bit tg);
    bit edge_s;
    pblrc = tk;
    trig  = tg;
    edge_s = tg && !m_trig_prev;
    m_trig_prev = tg;
    if (tk) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    if (edge_s) begin
      if (m_state == 0) begin
        m_phase = 16'd0;
        m_vol = 0;
      end
      m_freq = 2048; m_sw = 0; m_dc = 0; m_state = 1;
    end else if (tk && m_state != 0) begin
      m_phase = m_phase + 16'(m_freq);
      m_sw++;
      if (m_sw == 4) begin
        m_sw = 0;
        m_freq = (m_freq - 8 < 512) ? 512 : m_freq - 8;
      end
      if (m_state == 1) begin
        if (m_vol + 32 >= 255) begin m_vol = 255; m_state = 2; end
        else m_vol += 32;
      end else begin
        m_dc++;
        if (m_dc == 16) begin
          m_dc = 0;
          m_vol--;
          if (m_vol == 0) m_state = 0;
        end
      end
    end
    if (tk) begin
      exp_q.push_back(16'(exp_sample()));
      exp_t_q.push_back(cyc + 2);
    end
  endtask

  task automatic step(input bit tk, input bit tg);
    @(posedge mclk); #1;
    apply(tk, tg);
  endtask

  bit trig_lvl = 1'b0;

  task automatic tick();
    step(1'b1, trig_lvl);
    repeat (3) step(1'b0, trig_lvl);
  endtask

  task automatic fire();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    trig_lvl = 1'b0;
  endtask

  task automatic do_reset(input bit hold_trig);
    @(posedge mclk); #2;
    rst = 1'b0;
    pblrc = 1'b0;
    trig = hold_trig;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_volume", int'(volume_out), 0);
    chk("reset_valid", int'(sample_valid), 0);
    repeat (2) @(posedge mclk);
    model_reset();
    exp_q.delete();
    exp_t_q.delete();
    @(posedge mclk); #1;
    rst = 1'b1;
    apply(1'b0, hold_trig);
  endtask

  // monitor: every sample_valid must match the oldest expectation, on time
  always @(negedge mclk) begin
    if (rst && sample_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        logic [15:0] e;
        int t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        chk("sample", int'(p_sample_buffer), int'($signed(e)));
        chk("valid_cycle", cyc, t);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    repeat (3) @(posedge mclk);
    #1;
    chk("por_busy", int'(busy), 0);
    chk("por_volume", int'(volume_out), 0);
    chk("por_sample", int'(p_sample_buffer), 0);
    chk("por_valid", int'(sample_valid), 0);
    @(posedge mclk); #1;
    rst = 1'b1;
    apply(1'b0, 1'b0);

    // idle ticks: zero output, busy stays low
    repeat (3) tick();
    chk("idle_busy", int'(busy), 0);

    // pure-tone note: attack ramp, saturation, first decay step
    noise_mix = 4'd0;
    fire();
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("attack_vol", int'(volume_out), (i == 8) ? 255 : 32 * i);
    end
    chk("decay_entered", int'(dbg_state), 2);
    repeat (16) tick();
    chk("decay_254", int'(volume_out), 254);
    chk("decay_busy", int'(busy), 1);

    // continue with partial noise through sweep clamp down to volume 100
    noise_mix = 4'd7;
    guard = 0;
    while (m_vol != 100 && guard < 3000) begin
      tick();
      guard++;
    end
    chk("reach_100", int'(volume_out), 100);

    // retrigger in decay keeps volume and phase
    fire();
    chk("retrig_state", int'(dbg_state), 1);
    chk("retrig_vol", int'(volume_out), 100);
    tick();
    chk("retrig_vol_next", int'(volume_out), 132);
    repeat (5) tick();

    // reset mid-note with trig held across release: exactly one fire
    do_reset(1'b1);
    trig_lvl = 1'b1;
    step(1'b0, 1'b1);
    chk("held_trig_fire", int'(busy), 1);
    chk("held_trig_vol", int'(volume_out), 0);
    tick();
    tick();
    chk("held_trig_vol2", int'(volume_out), 64);
    trig_lvl = 1'b0;
    repeat (4) tick();

    // trigger edge coincident with a tick
    do_reset(1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("coinc_vol", int'(volume_out), 0);
    chk("coinc_state", int'(dbg_state), 1);
    tick();
    chk("coinc_next_vol", int'(volume_out), 32);

    // full-noise run to the end of the note
    noise_mix = 4'd15;
    guard = 0;
    while (m_state != 0 && guard < 5000) begin
      tick();
      guard++;
    end
    chk("end_busy", int'(busy), 0);
    chk("end_volume", int'(volume_out), 0);
    chk("end_state", int'(dbg_state), 0);
    repeat (3) tick();
    chk("end_sample", int'(p_sample_buffer), 0);

    repeat (6) @(posedge mclk);
    #1;
    chk("pending_samples", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
